aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule generator. Sits directly upstream of the encryption core and replaces its hard-wired key with round keys computed at run time.
- Accepts a 128-bit cipher key on a start handshake and produces round keys 0..10, one per clock, on a streaming output.
- Stores all 11 round keys in an internal bank, which the cipher can read back by round index.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_expand.sv | 125 ++++++++++++
 tb/tb_aes_key_expand.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and tables: key-schedule sizes, round constants and the
// forward S-box (also used by the cipher's SubBytes stage).
package aes_pkg;

   localparam int unsigned AES_NR  = 10;
   localparam int unsigned AES_NK  = 4;
   localparam int unsigned AES_BLK = 128;

   typedef enum logic {
      KX_IDLE,
      KX_EXPAND
   } kx_state_t;

   // Entry 0 is unused: round keys 1..10 consume rcon[1..10].
   localparam logic [7:0] AES_RCON [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   localparam logic [7:0] AES_SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
      if (rnd > 4'd10) return '0;
      return AES_RCON[rnd];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box lookup for one byte.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   assign out_o = AES_SBOX[in_i];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..NR one per clock after a
// start pulse and keeps the whole schedule in a bank readable by round index.
module aes_key_expand
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_index,
   output logic [127:0] rk_out,
   output logic         done,
   output logic         keys_ready,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
);

   localparam logic [3:0] LAST = 4'(NR);

   kx_state_t    state_q;
   logic [127:0] rk_q;
   logic [3:0]   idx_q;
   logic         valid_q;
   logic         busy_q;
   logic         done_q;
   logic         ready_q;
   logic [127:0] rd_key_q;
   logic [127:0] bank_q [0:NR];

   logic [31:0]  rot_w;
   logic [31:0]  sub_w;
   logic [31:0]  t_w;
   logic [31:0]  n0, n1, n2, n3;
   logic [3:0]   idx_d;
   logic [127:0] rk_d;

   // SubWord(RotWord(w3)): last word of the current key, rotated left one byte.
   assign rot_w = {rk_q[23:0], rk_q[31:24]};

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .in_i  (rot_w[8*g +: 8]),
         .out_o (sub_w[8*g +: 8])
      );
   end

   always_comb begin
      idx_d = idx_q + 4'd1;
      t_w   = sub_w ^ {aes_rcon(idx_d), 24'h000000};
      n0    = rk_q[127:96] ^ t_w;
      n1    = rk_q[95:64]  ^ n0;
      n2    = rk_q[63:32]  ^ n1;
      n3    = rk_q[31:0]   ^ n2;
      rk_d  = {n0, n1, n2, n3};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= KX_IDLE;
         rk_q    <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            KX_IDLE: begin
               valid_q <= 1'b0;
               done_q  <= 1'b0;
               if (start) begin
                  state_q <= KX_EXPAND;
                  rk_q    <= key_in;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            KX_EXPAND: begin
               if (idx_q == LAST) begin
                  state_q <= KX_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  rk_q   <= rk_d;
                  idx_q  <= idx_d;
                  done_q <= (idx_d == LAST);
               end
            end
            default: state_q <= KX_IDLE;
         endcase
      end
   end

   // Bank captures each key while it is on the streaming output.
   always_ff @(posedge clk) begin
      if (valid_q) bank_q[idx_q] <= rk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_key_q <= '0;
      end else if (rd_idx <= LAST) begin
         rd_key_q <= bank_q[rd_idx];
      end else begin
         rd_key_q <= '0;
      end
   end

   assign busy       = busy_q;
   assign rk_valid   = valid_q;
   assign rk_index   = idx_q;
   assign rk_out     = rk_q;
   assign done       = done_q;
   assign keys_ready = ready_q;
   assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: a reference key schedule built from a
// computed S-box feeds a stream scoreboard; FIPS-197 vectors are checked directly.
module tb_aes_key_expand;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic [3:0]   rk_index;
   logic [127:0] rk_out;
   logic         done;
   logic         keys_ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;

   aes_key_expand #(.NR(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .rk_valid   (rk_valid),
      .rk_index   (rk_index),
      .rk_out     (rk_out),
      .done       (done),
      .keys_ready (keys_ready),
      .rd_idx     (rd_idx),
      .rd_key     (rd_key)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      logic         done;
   } exp_t;

   exp_t         sbq[$];
   int           total = 0;
   int           bad = 0;
   logic [7:0]   tb_sbox  [0:255];
   logic [127:0] exp_keys [0:10];
   logic [127:0] obs_keys [0:15];

   localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from first principles: multiplicative inverse then affine transform.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] model_next(input logic [127:0] p, input logic [7:0] rc);
      logic [31:0] w3, t, a, b, c, d;
      w3 = p[31:0];
      t  = {tb_sbox[w3[23:16]], tb_sbox[w3[15:8]], tb_sbox[w3[7:0]], tb_sbox[w3[31:24]]}
         ^ {rc, 24'h000000};
      a  = p[127:96] ^ t;
      b  = p[95:64] ^ a;
      c  = p[63:32] ^ b;
      d  = p[31:0] ^ c;
      return {a, b, c, d};
   endfunction

   task automatic push_schedule(input logic [127:0] key, input int n);
      logic [127:0] k;
      logic [7:0]   rc;
      exp_t         e;
      k  = key;
      rc = 8'h01;
      for (int i = 0; i <= 10; i++) begin
         if (i > 0) begin
            k  = model_next(k, rc);
            rc = xtime(rc);
         end
         exp_keys[i] = k;
         if (i < n) begin
            e.idx  = 4'(i);
            e.key  = k;
            e.done = (i == 10);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rk_valid === 1'b1) begin
            obs_keys[rk_index] = rk_out;
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL stream_unexpected: got idx %0d key %h want no rk_valid", rk_index, rk_out);
            end else begin
               e = sbq.pop_front();
               total++;
               if (rk_index !== e.idx) begin
                  bad++;
                  $display("FAIL stream_idx: got %0d want %0d", rk_index, e.idx);
               end
               total++;
               if (rk_out !== e.key) begin
                  bad++;
                  $display("FAIL stream_key[%0d]: got %h want %h", e.idx, rk_out, e.key);
               end
               total++;
               if (done !== e.done) begin
                  bad++;
                  $display("FAIL stream_done[%0d]: got %b want %b", e.idx, done, e.done);
               end
            end
         end else if (done !== 1'b0) begin
            total++; bad++;
            $display("FAIL done_without_valid: got %b want 0", done);
         end
      end
   endtask

   task automatic start_run(input logic [127:0] key);
      @(posedge clk); #1;
      start  = 1'b1;
      key_in = key;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (busy === 1'b0 && sbq.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL wait_idle: got busy=%b pending=%0d want idle and empty", busy, sbq.size());
      end
   endtask

   task automatic wait_index(input logic [3:0] idx, output bit found);
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         @(negedge clk);
         if (rk_valid === 1'b1 && rk_index === idx) found = 1'b1;
      end
      if (!found) begin
         total++; bad++;
         $display("FAIL wait_index: got no rk_index %0d want it within 30 cycles", idx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; key_in = KEY_ALT; rd_idx = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (rk_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid: got %b want 0", rk_valid); end
      total++; if (rk_index !== 4'd0)   begin bad++; $display("FAIL rst_index: got %0d want 0", rk_index); end
      total++; if (rk_out !== '0)       begin bad++; $display("FAIL rst_rk_out: got %h want 0", rk_out); end
      total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      total++; if (keys_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", keys_ready); end
      total++; if (rd_key !== '0)       begin bad++; $display("FAIL rst_rd_key: got %h want 0", rd_key); end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_beats_start: got busy %b want 0", busy); end
   endtask

   task automatic test_fips();
      push_schedule(KEY_FIPS, 11);
      start_run(KEY_FIPS);
      wait_idle();
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL fips_ready: got %b want 1", keys_ready); end
      total++; if (rk_valid !== 1'b0)   begin bad++; $display("FAIL fips_valid_end: got %b want 0", rk_valid); end
      total++; if (obs_keys[0] !== KEY_FIPS) begin bad++; $display("FAIL fips_rk0: got %h want %h", obs_keys[0], KEY_FIPS); end
      total++; if (obs_keys[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
         begin bad++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", obs_keys[1]); end
      total++; if (obs_keys[2] !== 128'hf2c295f27a96b9435935807a7359f67f)
         begin bad++; $display("FAIL fips_rk2: got %h want f2c295f27a96b9435935807a7359f67f", obs_keys[2]); end
      total++; if (obs_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
         begin bad++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_keys[10]); end
   endtask

   task automatic test_readback();
      logic [127:0] want;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         rd_idx = 4'(i);
         @(posedge clk);
         @(negedge clk);
         want = (i <= 10) ? exp_keys[i] : '0;
         total++;
         if (rd_key !== want) begin bad++; $display("FAIL readback[%0d]: got %h want %h", i, rd_key, want); end
      end
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL readback_ready: got %b want 1", keys_ready); end
   endtask

   task automatic test_zero_key();
      push_schedule('0, 11);
      start_run('0);
      wait_idle();
      total++; if (obs_keys[1] !== 128'h62636363626363636263636362636363)
         begin bad++; $display("FAIL zero_rk1: got %h want 62636363626363636263636362636363", obs_keys[1]); end
      total++; if (obs_keys[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
         begin bad++; $display("FAIL zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", obs_keys[10]); end
   endtask

   task automatic test_start_ignored();
      bit found;
      push_schedule(KEY_ALT, 11);
      start_run(KEY_ALT);
      wait_index(4'd5, found);
      start  = 1'b1;
      key_in = KEY_FIPS;
      @(posedge clk); #1;
      start  = 1'b0;
      wait_idle();
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL ignored_ready: got %b want 1", keys_ready); end
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_no_restart: got busy %b want 0", busy); end
   endtask

   task automatic test_abort();
      bit found;
      push_schedule(KEY_FIPS, 5);
      start_run(KEY_FIPS);
      wait_index(4'd4, found);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      total++; if (rk_valid !== 1'b0)   begin bad++; $display("FAIL abort_valid: got %b want 0", rk_valid); end
      total++; if (keys_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", keys_ready); end
      total++; if (rk_out !== '0)       begin bad++; $display("FAIL abort_rk_out: got %h want 0", rk_out); end
      repeat (12) @(negedge clk);
      total++; if (keys_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_hold: got %b want 0", keys_ready); end
      total++; if (sbq.size() != 0)     begin bad++; $display("FAIL abort_pending: got %0d want 0", sbq.size()); end
   endtask

   task automatic test_restart();
      push_schedule(KEY_FIPS, 11);
      start_run(KEY_FIPS);
      wait_idle();
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL restart_ready: got %b want 1", keys_ready); end
      @(posedge clk); #1;
      rd_idx = 4'd10;
      @(posedge clk);
      @(negedge clk);
      total++; if (rd_key !== exp_keys[10]) begin bad++; $display("FAIL restart_rd10: got %h want %h", rd_key, exp_keys[10]); end
   endtask

   task automatic test_back_to_back();
      bit found;
      push_schedule(KEY_ALT, 11);
      start_run(KEY_ALT);
      wait_index(4'd10, found);
      @(posedge clk); #1;
      push_schedule(KEY_FIPS, 11);
      start  = 1'b1;
      key_in = KEY_FIPS;
      @(negedge clk);
      total++; if (busy !== 1'b0)       begin bad++; $display("FAIL b2b_gap_busy: got %b want 0", busy); end
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready: got %b want 1", keys_ready); end
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      total++; if (rk_valid !== 1'b1)   begin bad++; $display("FAIL b2b_second_valid: got %b want 1", rk_valid); end
      total++; if (keys_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_ready: got %b want 0", keys_ready); end
      wait_idle();
      total++; if (keys_ready !== 1'b1) begin bad++; $display("FAIL b2b_final_ready: got %b want 1", keys_ready); end
   endtask

   initial begin
      build_sbox();
      fork
         monitor();
      join_none
      test_reset();
      test_fips();
      test_readback();
      test_zero_key();
      test_start_ignored();
      test_abort();
      test_restart();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
